apb_slave_mem: RTL and testbench

//  APB completer (slave) with word-addressed register memory: the responder for the
//  APB transfers issued by Bridge_Top. Decodes one Pselx bit, inserts programmable

---
 rtl/apb_slave_mem.sv | 153 +++++++++++++++
 tb/tb_apb_slave_mem.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB completer with a word-addressed register memory.
// Responds to one bit of the one-hot Pselx, stretches each access phase by
// WAIT_STATES cycles through a registered Pready, and flags out-of-range or
// misaligned addresses with Pslverr. Address and direction are latched at the
// setup cycle; Pwdata is taken live on the completion edge.
//
// Handshake: a transfer starts with a setup cycle (own select bit high,
// Penable low) seen in IDLE. It completes on the rising edge where the select
// bit, Penable and Pready are all high. Pready is high for exactly one cycle
// per transfer, and Pslverr is meaningful only while Pready is high. Dropping
// the select bit before completion abandons the transfer with no memory change.
module apb_slave_mem #(
  parameter int          SEL_INDEX   = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_LOG2  = 6,
  parameter int          WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic        o_dbg_state
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [31:0]             r_addr;
  logic                    r_write;
  logic [3:0]              r_cnt;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_sel;
  logic [31:0]             w_dec_addr;
  logic                    w_dec_write;
  logic [29:0]             w_word;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_err;
  logic                    w_setup;
  logic                    w_abort;
  logic                    w_done;
  logic                    w_tick;
  logic                    w_respond;
  logic                    w_ready_nxt;
  logic                    w_slverr_nxt;
  logic                    w_rd_load;
  logic                    w_mem_we;

  assign w_sel       = Pselx[SEL_INDEX];
  assign o_dbg_state = r_state;

  // Decode the live address during setup (zero-wait responses are produced on
  // that edge) and the latched copy once in ACCESS.
  assign w_dec_addr  = (r_state == S_IDLE) ? Paddr  : r_addr;
  assign w_dec_write = (r_state == S_IDLE) ? Pwrite : r_write;
  assign w_word      = w_dec_addr[31:2] - BASE_ADDR[31:2];
  assign w_idx       = w_word[DEPTH_LOG2-1:0];
  assign w_err       = (w_dec_addr < BASE_ADDR) | (|w_word[29:DEPTH_LOG2]) |
                       (|w_dec_addr[1:0]);

  // Transfer events derived from the current state and bus inputs.
  assign w_setup   = (r_state == S_IDLE)   &  w_sel & ~Penable;
  assign w_abort   = (r_state == S_ACCESS) & ~w_sel;
  assign w_done    = (r_state == S_ACCESS) &  w_sel & Penable & Pready;
  assign w_tick    = (r_state == S_ACCESS) &  w_sel & ~Pready & (r_cnt != 4'd0);
  assign w_respond = (w_setup & (WS == 4'd0)) | (w_tick & (r_cnt == 4'd1));

  // State register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: setup enters ACCESS, completion or abort returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_setup)           w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_abort || w_done) w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered response and the strobes for
  // read-data load and memory write.
  always_comb begin
    w_ready_nxt  = Pready;
    w_slverr_nxt = Pslverr;
    if (w_respond) begin
      w_ready_nxt  = 1'b1;
      w_slverr_nxt = w_err;
    end
    if (w_abort || w_done) begin
      w_ready_nxt  = 1'b0;
      w_slverr_nxt = 1'b0;
    end
    w_rd_load = w_respond & (~w_dec_write | w_err);
    w_mem_we  = w_done & r_write & ~Pslverr;
  end

  // Transfer context latched at setup, plus the wait-state down-counter.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_addr  <= 32'd0;
      r_write <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (w_setup) begin
      r_addr  <= Paddr;
      r_write <= Pwrite;
      r_cnt   <= WS;
    end else if (w_tick) begin
      r_cnt   <= r_cnt - 4'd1;
    end else if (w_abort || w_done) begin
      r_cnt   <= 4'd0;
    end
  end

  // Registered response outputs; read data holds between completed reads.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= 32'd0;
    end else begin
      Pready  <= w_ready_nxt;
      Pslverr <= w_slverr_nxt;
      if (w_rd_load) Prdata <= w_err ? 32'd0 : r_mem[w_idx];
    end
  end

  // Word memory, cleared by reset and written on the completion edge.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_mem_we) begin
      r_mem[w_idx] <= Pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem. Three instances share the APB inputs and
// answer different Pselx bits, giving three wait-state settings on one bus:
//   u_a: SEL_INDEX=0, WAIT_STATES=0
//   u_b: SEL_INDEX=1, WAIT_STATES=1
//   u_c: SEL_INDEX=2, WAIT_STATES=3
module tb_apb_slave_mem;

  logic        clk;
  logic        rst;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic        dbg [3];

  int checks = 0;
  int errors = 0;

  apb_slave_mem #(.SEL_INDEX(0), .WAIT_STATES(0)) u_a (
    .Hclk(clk), .Hreset(rst), .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[0]), .Pready(pready[0]),
    .Pslverr(pslverr[0]), .o_dbg_state(dbg[0]));

  apb_slave_mem #(.SEL_INDEX(1), .WAIT_STATES(1)) u_b (
    .Hclk(clk), .Hreset(rst), .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[1]), .Pready(pready[1]),
    .Pslverr(pslverr[1]), .o_dbg_state(dbg[1]));

  apb_slave_mem #(.SEL_INDEX(2), .WAIT_STATES(3)) u_c (
    .Hclk(clk), .Hreset(rst), .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[2]), .Pready(pready[2]),
    .Pslverr(pslverr[2]), .o_dbg_state(dbg[2]));

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    pselx   = 3'b000;
    penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One complete transfer to instance s. Returns read data, error flag and
  // the number of access cycles with Pready low. Ends 1 time unit after the
  // completion edge with the bus released.
  task automatic xfer(input int s, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic err, output int waits);
    logic got;
    pselx   = 3'b001 << s;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    got   = 1'b0;
    rd    = 32'd0;
    err   = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (pready[s]) begin
        got = 1'b1;
        rd  = prdata[s];
        err = pslverr[s];
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    chk("pready_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    chk("pready_drops_after_done", 32'(pready[s]), 32'd0);
    pselx   = 3'b000;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;

  initial begin
    // Reset
    rst = 1'b1; pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset_prdata",  prdata[s],       32'd0);
      chk("reset_pready",  32'(pready[s]),  32'd0);
      chk("reset_pslverr", 32'(pslverr[s]), 32'd0);
      chk("reset_state",   32'(dbg[s]),     32'd0);
    end

    // Test 1: one wait state, write then read back
    xfer(1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, rd, err, waits);
    chk("t1_wr_waits", 32'(waits), 32'd1);
    chk("t1_wr_err",   32'(err),   32'd0);
    xfer(1, 1'b0, 32'h8000_0004, 32'h0, rd, err, waits);
    chk("t1_rd_waits", 32'(waits), 32'd1);
    chk("t1_rd_err",   32'(err),   32'd0);
    chk("t1_rd_data",  rd,         32'hDEAD_BEEF);

    // Test 2: zero wait states, back-to-back writes then reads
    xfer(0, 1'b1, 32'h8000_0000, 32'd1, rd, err, waits);
    chk("t2_wr0_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 32'h8000_0008, 32'd2, rd, err, waits);
    chk("t2_wr1_waits", 32'(waits), 32'd0);
    chk("t2_wr1_err",   32'(err),   32'd0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, err, waits);
    chk("t2_rd0_waits", 32'(waits), 32'd0);
    chk("t2_rd0_data",  rd,         32'd1);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, rd, err, waits);
    chk("t2_rd1_data",  rd,         32'd2);
    chk("t2_other_ready_b", 32'(pready[1]), 32'd0);
    chk("t2_other_ready_c", 32'(pready[2]), 32'd0);
    chk("t2_b_prdata_held", prdata[1], 32'hDEAD_BEEF);

    // Test 3: error responses
    xfer(0, 1'b0, 32'h8000_0100, 32'h0, rd, err, waits);
    chk("t3_oor_err",   32'(err), 32'd1);
    chk("t3_oor_data",  rd,       32'd0);
    chk("t3_oor_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 32'h8000_0002, 32'hFFFF_FFFF, rd, err, waits);
    chk("t3_misalign_err", 32'(err), 32'd1);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, err, waits);
    chk("t3_unchanged_err",  32'(err), 32'd0);
    chk("t3_unchanged_data", rd,       32'd1);
    xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, rd, err, waits);
    chk("t3_below_base_err", 32'(err), 32'd1);
    xfer(0, 1'b0, 32'h8000_00FC, 32'h0, rd, err, waits);
    chk("t3_last_word_err", 32'(err), 32'd0);

    // Test 4: three wait states, select dropped after two access cycles
    pselx = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0000; pwdata = 32'h1234;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("t4_acc1_ready", 32'(pready[2]), 32'd0);
    @(posedge clk); #1;
    chk("t4_acc2_ready", 32'(pready[2]), 32'd0);
    chk("t4_acc2_state", 32'(dbg[2]),    32'd1);
    pselx = 3'b000; penable = 1'b0;
    @(posedge clk); #1;
    chk("t4_abort_ready", 32'(pready[2]), 32'd0);
    chk("t4_abort_state", 32'(dbg[2]),    32'd0);
    xfer(2, 1'b0, 32'h8000_0000, 32'h0, rd, err, waits);
    chk("t4_rd_waits", 32'(waits), 32'd3);
    chk("t4_rd_data",  rd,         32'd0);

    // Test 5: reset during a wait state
    xfer(1, 1'b1, 32'h8000_0010, 32'hA5A5, rd, err, waits);
    chk("t5_wr_err", 32'(err), 32'd0);
    pselx = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8000_0010;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("t5_wait_state", 32'(dbg[1]),    32'd1);
    chk("t5_wait_ready", 32'(pready[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_prdata",  prdata[1],       32'd0);
    chk("t5_rst_pready",  32'(pready[1]),  32'd0);
    chk("t5_rst_pslverr", 32'(pslverr[1]), 32'd0);
    chk("t5_rst_state",   32'(dbg[1]),     32'd0);
    pselx = 3'b000; penable = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h8000_0010, 32'h0, rd, err, waits);
    chk("t5_rd_data", rd, 32'd0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, err, waits);
    chk("t5_a_cleared", rd, 32'd0);
    pselx = 3'b010; penable = 1'b1;
    @(posedge clk); #1;
    chk("t5_penonly_ready1", 32'(pready[1]), 32'd0);
    chk("t5_penonly_state",  32'(dbg[1]),    32'd0);
    @(posedge clk); #1;
    chk("t5_penonly_ready2", 32'(pready[1]), 32'd0);
    idle(1);

    // Test 6: four-beat burst, zero wait states
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 32'h8000_0020 + 32'(i * 4), 32'hB000_0000 + 32'(i), rd, err, waits);
      chk("t6_wr_err",   32'(err),   32'd0);
      chk("t6_wr_waits", 32'(waits), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, 32'h8000_0020 + 32'(i * 4), 32'h0, rd, err, waits);
      chk("t6_rd_err",  32'(err), 32'd0);
      chk("t6_rd_data", rd,       32'hB000_0000 + 32'(i));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
